keypad_scan_ctrl: RTL and testbench

//  Sequences the 3-column x 4-row matrix keypad: drives one-hot column strobes, samples the row

---
 rtl/keypad_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans a 3-column x 4-row matrix keypad with one-hot column strobes.
// Row returns are synchronised, then sampled once per column dwell (tick).
// Press and release are both debounced. Each accepted press yields one
// 4-bit key code, delivered over a valid/ready handshake. A press that
// arrives while an earlier code is still undelivered is dropped, and the
// sticky overrun flag is set.

module keypad_scan_ctrl #(
   parameter int CLK_DIV  = 2700,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [2:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overrun,
   input  logic       overrun_clr
);

   // Tick counter width covers 0..CLK_DIV-1.
   localparam int TICK_W = $clog2(CLK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

   // The debounce counter has headroom for DEBOUNCE+1. The increment
   // taken on the deciding sample therefore never wraps, even when
   // DEBOUNCE is 1.
   localparam int CNT_W = $clog2(DEBOUNCE + 2);
   localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   // Scan FSM state encoding.
   localparam logic [1:0] ST_SCAN     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_PRESSED  = 2'd2;
   localparam logic [1:0] ST_RELEASE  = 2'd3;

   // True when exactly one row line is active.
   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   // Rotate the column strobe: 001 -> 010 -> 100 -> 001.
   function automatic logic [2:0] next_col(input logic [2:0] c);
      return {c[1:0], c[2]};
   endfunction

   // Key code from the active column strobe and the active row line.
   function automatic logic [3:0] key_map(input logic [2:0] c, input logic [3:0] r);
      logic [3:0] code;
      code = 4'h0;
      unique case (r)
         4'b0001: code = c[0] ? 4'h1 : (c[1] ? 4'h2 : 4'h3);
         4'b0010: code = c[0] ? 4'h4 : (c[1] ? 4'h5 : 4'h6);
         4'b0100: code = c[0] ? 4'h7 : (c[1] ? 4'h8 : 4'h9);
         4'b1000: code = c[0] ? 4'hA : (c[1] ? 4'h0 : 4'hB);
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   logic [3:0]        row_s1_q;
   logic [3:0]        rs_q;
   logic [TICK_W-1:0] tick_cnt_q;
   logic              tick;

   logic [1:0]        state_q, state_d;
   logic [2:0]        col_q, col_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [3:0]        lrow_q, lrow_d;
   logic              held_q, held_d;

   logic              emit;
   logic [3:0]        emit_code;

   logic              valid_q, valid_d;
   logic [3:0]        code_q, code_d;
   logic              ovr_q, ovr_d;
   logic              accept;
   logic              ovr_set;

   // Two-flop synchroniser for the asynchronous row returns.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_s1_q <= 4'd0;
         rs_q     <= 4'd0;
      end else begin
         row_s1_q <= row;
         rs_q     <= row_s1_q;
      end
   end

   // Free-running dwell counter. It is never paused, so the tick phase
   // depends only on the time since reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_q <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + TICK_ONE;
      end
   end

   assign tick = (tick_cnt_q == TICK_LAST);

   // Scan/debounce FSM. It only acts on a tick and holds otherwise.
   // The column strobe stays parked on the pressed key's column from
   // DEBOUNCE through RELEASE. col_q therefore doubles as the latched
   // column index, and keys on other columns are never seen.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      cnt_d     = cnt_q;
      lrow_d    = lrow_q;
      emit      = 1'b0;
      emit_code = key_map(col_q, lrow_q);
      cnt_inc   = cnt_q + CNT_ONE;
      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               if (is_onehot4(rs_q)) begin
                  lrow_d = rs_q;
                  cnt_d  = CNT_ONE;
                  if (DEBOUNCE == 1) begin
                     emit      = 1'b1;
                     emit_code = key_map(col_q, rs_q);
                     state_d   = ST_PRESSED;
                  end else begin
                     state_d = ST_DEBOUNCE;
                  end
               end else begin
                  col_d = next_col(col_q);
               end
            end
            ST_DEBOUNCE: begin
               if (rs_q == lrow_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= DEB_TARGET) begin
                     emit    = 1'b1;
                     state_d = ST_PRESSED;
                  end
               end else begin
                  state_d = ST_SCAN;
                  col_d   = next_col(col_q);
               end
            end
            ST_PRESSED: begin
               if (rs_q == 4'd0) begin
                  cnt_d   = CNT_ONE;
                  state_d = ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (rs_q == 4'd0) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= DEB_TARGET) begin
                     state_d = ST_SCAN;
                     col_d   = next_col(col_q);
                  end
               end else begin
                  state_d = ST_PRESSED;
               end
            end
            default: begin
               state_d = ST_SCAN;
               col_d   = 3'b001;
            end
         endcase
      end
      held_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
   end

   // FSM state, column strobe, debounce count and latched row.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_SCAN;
         col_q   <= 3'b001;
         cnt_q   <= '0;
         lrow_q  <= 4'd0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         lrow_q  <= lrow_d;
         held_q  <= held_d;
      end
   end

   // Output handshake. A new code may replace the pending one only in
   // the cycle that the pending one is accepted. Otherwise the new press
   // is dropped and flagged. A fresh overrun event takes priority over a
   // same-cycle clear.
   always_comb begin
      accept  = valid_q & key_ready;
      valid_d = valid_q;
      code_d  = code_q;
      ovr_set = 1'b0;
      if (emit) begin
         if (!valid_q || accept) begin
            code_d  = emit_code;
            valid_d = 1'b1;
         end else begin
            ovr_set = 1'b1;
         end
      end else if (accept) begin
         valid_d = 1'b0;
      end
      if (ovr_set) begin
         ovr_d = 1'b1;
      end else if (overrun_clr) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Pending key code, valid flag and sticky overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         code_q  <= 4'd0;
         ovr_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         code_q  <= code_d;
         ovr_q   <= ovr_d;
      end
   end

   assign col       = col_q;
   assign key_valid = valid_q;
   assign key_code  = code_q;
   assign key_held  = held_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl
// Directed scenarios followed by random key presses. A small keypad model
// drives the row lines from the column strobe.

module tb_keypad_scan_ctrl;

   localparam int CLK_DIV  = 4;
   localparam int DEBOUNCE = 3;
   localparam int LAT_MAX  = (3 + DEBOUNCE) * CLK_DIV + 2;
   localparam logic [3:0] CODE_TAB [4][3] = '{'{4'h1, 4'h2, 4'h3},
                                              '{4'h4, 4'h5, 4'h6},
                                              '{4'h7, 4'h8, 4'h9},
                                              '{4'hA, 4'h0, 4'hB}};

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row;
   logic [2:0] col;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic       key_held;
   logic       overrun;
   logic       overrun_clr;

   logic       key_down;
   logic [2:0] key_col;
   logic [3:0] key_row;

   int errors = 0;
   int checks = 0;
   int cyc;

   keypad_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk         (clk),
      .reset       (reset),
      .row         (row),
      .col         (col),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ready   (key_ready),
      .key_held    (key_held),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   // Matrix keypad: the closed switch connects its row to its column strobe.
   always_comb row = (key_down && (col == key_col)) ? key_row : 4'b0000;

   // Edges since reset. A tick edge is one where cyc becomes a multiple of CLK_DIV.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_col(input string tag, input logic [2:0] target, input int budget);
      int n = 0;
      while (col !== target && n < budget) begin
         step(1);
         n++;
      end
      check(tag, 32'(col), 32'(target));
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (key_valid !== 1'b1 && n < budget) begin
         step(1);
         n++;
      end
      check(tag, 32'(key_valid), 32'd1);
   endtask

   task automatic wait_held(input string tag, input logic lvl, input int budget);
      int n = 0;
      while (key_held !== lvl && n < budget) begin
         step(1);
         n++;
      end
      check(tag, 32'(key_held), 32'(lvl));
   endtask

   task automatic wait_tick();
      int n = 0;
      step(1);
      while ((cyc % CLK_DIV) != 0 && n < CLK_DIV) begin
         step(1);
         n++;
      end
   endtask

   task automatic press(input logic [2:0] c, input logic [3:0] r);
      key_col  = c;
      key_row  = r;
      key_down = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] rc;
      logic [3:0] rr;
      int kc;
      int kr;
      int n;

      reset       = 1'b1;
      key_ready   = 1'b0;
      overrun_clr = 1'b0;
      key_down    = 1'b0;
      key_col     = 3'b001;
      key_row     = 4'b0000;

      // 1. reset state and free scanning
      step(3);
      reset = 1'b0;
      check("rst_col", 32'(col), 32'(3'b001));
      check("rst_valid", 32'(key_valid), 32'd0);
      check("rst_held", 32'(key_held), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_code", 32'(key_code), 32'd0);
      step(3);
      check("scan_hold_col1", 32'(col), 32'(3'b001));
      step(1);
      check("scan_col2", 32'(col), 32'(3'b010));
      step(4);
      check("scan_col3", 32'(col), 32'(3'b100));
      step(4);
      check("scan_wrap", 32'(col), 32'(3'b001));

      // 2. key '5' and handshake
      wait_col("t2_col2", 3'b010, 16);
      press(3'b010, 4'b0010);
      wait_valid("t2_valid", LAT_MAX);
      check("t2_code", 32'(key_code), 32'h5);
      check("t2_held", 32'(key_held), 32'd1);
      check("t2_col_frozen", 32'(col), 32'(3'b010));
      key_ready = 1'b1;
      step(1);
      key_ready = 1'b0;
      check("t2_accept", 32'(key_valid), 32'd0);
      key_down = 1'b0;
      wait_held("t2_release", 1'b0, 40);

      // 3. press too short to debounce
      wait_col("t3_sync", 3'b010, 16);
      wait_col("t3_col3", 3'b100, 16);
      press(3'b100, 4'b0100);
      step(2 * CLK_DIV);
      check("t3_col_frozen", 32'(col), 32'(3'b100));
      check("t3_no_held", 32'(key_held), 32'd0);
      key_down = 1'b0;
      step(CLK_DIV);
      check("t3_col_adv", 32'(col), 32'(3'b001));
      check("t3_no_emit", 32'(key_valid), 32'd0);

      // 4. '*' left pending, then '#' overruns
      press(3'b001, 4'b1000);
      wait_valid("t4_valid", LAT_MAX);
      check("t4_code_star", 32'(key_code), 32'hA);
      key_down = 1'b0;
      wait_held("t4_rel1", 1'b0, 40);
      press(3'b100, 4'b1000);
      wait_held("t4_held2", 1'b1, LAT_MAX);
      check("t4_code_kept", 32'(key_code), 32'hA);
      check("t4_valid_kept", 32'(key_valid), 32'd1);
      check("t4_overrun", 32'(overrun), 32'd1);
      step(3);
      check("t4_overrun_sticky", 32'(overrun), 32'd1);
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
      check("t4_overrun_clr", 32'(overrun), 32'd0);
      key_down = 1'b0;
      wait_held("t4_rel2", 1'b0, 40);
      key_ready = 1'b1;
      step(1);
      key_ready = 1'b0;
      check("t4_drain", 32'(key_valid), 32'd0);

      // 5. '0' with a one-tick release bounce
      press(3'b010, 4'b1000);
      wait_valid("t5_valid", LAT_MAX);
      check("t5_code", 32'(key_code), 32'h0);
      key_ready = 1'b1;
      step(1);
      key_ready = 1'b0;
      check("t5_accept", 32'(key_valid), 32'd0);
      wait_tick();
      key_down = 1'b0;
      wait_tick();
      check("t5_bounce_held", 32'(key_held), 32'd1);
      key_down = 1'b1;
      wait_tick();
      check("t5_repress_held", 32'(key_held), 32'd1);
      step(3 * CLK_DIV);
      check("t5_single_emit", 32'(key_valid), 32'd0);
      key_down = 1'b0;
      wait_held("t5_release", 1'b0, 40);
      check("t5_no_late_emit", 32'(key_valid), 32'd0);

      // 6. reset mid-debounce, reset with a pending key, multi-bit rows
      wait_col("t6_sync", 3'b001, 16);
      wait_col("t6_col2", 3'b010, 16);
      press(3'b010, 4'b0001);
      wait_tick();
      wait_tick();
      reset = 1'b1;
      step(1);
      reset    = 1'b0;
      key_down = 1'b0;
      check("t6a_col", 32'(col), 32'(3'b001));
      check("t6a_valid", 32'(key_valid), 32'd0);
      check("t6a_held", 32'(key_held), 32'd0);
      step(5 * CLK_DIV);
      check("t6a_no_emit", 32'(key_valid), 32'd0);
      press(3'b100, 4'b0001);
      wait_valid("t6b_valid", LAT_MAX);
      check("t6b_code", 32'(key_code), 32'h3);
      reset = 1'b1;
      step(1);
      reset    = 1'b0;
      key_down = 1'b0;
      check("t6b_valid_clr", 32'(key_valid), 32'd0);
      check("t6b_code_clr", 32'(key_code), 32'd0);
      check("t6b_col", 32'(col), 32'(3'b001));
      check("t6b_held", 32'(key_held), 32'd0);
      press(3'b001, 4'b0011);
      wait_col("t6c_col2", 3'b010, 16);
      wait_col("t6c_col3", 3'b100, 16);
      wait_col("t6c_col1", 3'b001, 16);
      wait_col("t6c_col2b", 3'b010, 16);
      check("t6c_no_emit", 32'(key_valid), 32'd0);
      check("t6c_no_held", 32'(key_held), 32'd0);
      key_down = 1'b0;

      // random presses against the code table, with a random consumer
      for (int i = 0; i < 20; i++) begin
         kc = int'($urandom_range(0, 2));
         kr = int'($urandom_range(0, 3));
         rc = 3'b001 << kc;
         rr = 4'b0001 << kr;
         key_ready = 1'b0;
         step(int'($urandom_range(0, 9)));
         press(rc, rr);
         wait_valid("rnd_latency", LAT_MAX);
         check("rnd_code", 32'(key_code), 32'(CODE_TAB[kr][kc]));
         check("rnd_held", 32'(key_held), 32'd1);
         n = 0;
         while (key_valid === 1'b1 && n < 64) begin
            key_ready = 1'($urandom_range(0, 1));
            step(1);
            n++;
         end
         key_ready = 1'b0;
         check("rnd_accept", 32'(key_valid), 32'd0);
         step(int'($urandom_range(0, 12)));
         key_down = 1'b0;
         wait_held("rnd_release", 1'b0, 40);
         check("rnd_overrun", 32'(overrun), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
